// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
// Per-requester fields are packed with requester 1 in the upper slot.
interface alu_share_arbiter_if;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0][2:0] req_op;
    logic [1:0][7:0] req_a;
    logic [1:0][7:0] req_b;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [7:0]      rsp_result;
    logic [3:0]      rsp_flags;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One op in flight: IDLE accepts, EXEC drives the ALU, RESP holds the response.
module alu_share_arbiter #(
    parameter logic [2:0] ILLEGAL_OP = 3'b111
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus,
    output logic [2:0]           alu_op_o,
    output logic [7:0]           alu_a_o,
    output logic [7:0]           alu_b_o,
    input  logic [7:0]           alu_result_i,
    input  logic                 alu_zero_i,
    input  logic                 alu_overflow_i,
    input  logic                 alu_carry_i,
    output logic [7:0]           ops_done_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        gnt_q;
    logic        illegal_q;
    logic [2:0]  alu_op_q;
    logic [7:0]  alu_a_q;
    logic [7:0]  alu_b_q;
    logic [1:0]  rsp_valid_q;
    logic [7:0]  rsp_result_q;
    logic [3:0]  rsp_flags_q;
    logic [7:0]  ops_done_q;

    logic        gnt_d;
    logic        accept;
    logic        op_illegal;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        gnt_d = 1'b0;
        unique case (bus.req_valid)
            2'b01:   gnt_d = 1'b0;
            2'b10:   gnt_d = 1'b1;
            2'b11:   gnt_d = ~last_grant_q;
            default: gnt_d = 1'b0;
        endcase
    end

    assign accept     = rst_n && (state_q == IDLE) && (|bus.req_valid);
    assign op_illegal = (bus.req_op[gnt_d] == ILLEGAL_OP);

    assign bus.req_ready  = accept ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;

    assign alu_op_o   = alu_op_q;
    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign ops_done_o = ops_done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            illegal_q    <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            ops_done_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_grant_q <= gnt_d;
                        gnt_q        <= gnt_d;
                        illegal_q    <= op_illegal;
                        // Illegal ops never reach the ALU: its inputs stay at zero.
                        alu_op_q     <= op_illegal ? 3'b000 : bus.req_op[gnt_d];
                        alu_a_q      <= op_illegal ? 8'h00  : bus.req_a[gnt_d];
                        alu_b_q      <= op_illegal ? 8'h00  : bus.req_b[gnt_d];
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    alu_op_q     <= '0;
                    alu_a_q      <= '0;
                    alu_b_q      <= '0;
                    rsp_result_q <= illegal_q ? 8'h00 : alu_result_i;
                    rsp_flags_q  <= illegal_q ? 4'b1000
                                              : {1'b0, alu_carry_i, alu_overflow_i, alu_zero_i};
                    rsp_valid_q  <= gnt_q ? 2'b10 : 2'b01;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[gnt_q]) begin
                        rsp_valid_q <= '0;
                        ops_done_q  <= ops_done_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter ILLEGAL_OP, default 3'b111: op code rejected with an error response; the ALU is not consulted.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  synchronous active-low reset, sampled on clk rise.
REQ-005 req_valid  in  2  per-requester request valid; bit i is requester i.
REQ-006 req_ready  out  2  per-requester accept; at most one bit high per cycle.
REQ-007 req_op  in  6  {op1,op0}, 3 bits per requester.
REQ-008 req_a, req_b  in  16 each  {x1,x0}, 8 bits per requester.
REQ-009 alu_op  out  3  op driven to the shared combinational ALU.
REQ-010 alu_a, alu_b  out  8 each  operands to the ALU.
REQ-011 alu_result  in  8  ALU result; alu_zero, alu_overflow, alu_carry  in  1 each  ALU flags.
REQ-012 rsp_valid  out  2  per-requester response valid.
REQ-013 rsp_ready  in  2  per-requester response accept.
REQ-014 rsp_result  out  8  shared response data, meaningful only with the rsp_valid bit set.
REQ-015 rsp_flags  out  4  {err,carry,overflow,zero}.
REQ-016 ops_done  out  8  count of completed responses; wraps 255->0.

Function
REQ-017 FSM states: IDLE, EXEC, RESP. Only one op is in flight at a time.
REQ-018 IDLE: if any req_valid is high, assert req_ready for exactly one granted requester (combinational from req_valid and last_grant), register its op/a/b, record grant, go to EXEC.
REQ-019 Arbitration: round robin.
  - Single requester valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - last_grant updates on each accept.
REQ-020 req_ready SHALL be 0 in EXEC and RESP. A requester dropping req_valid before its handshake is legal and causes no grant.
REQ-021 EXEC, one cycle:
  - alu_op/alu_a/alu_b driven from the registered values.
  - alu_result and flags captured into response registers at end of cycle.
  - Go to RESP.
REQ-022 Outside EXEC, alu_op/alu_a/alu_b SHALL be held at 0.
REQ-023 If the registered op equals ILLEGAL_OP:
  - ALU outputs remain 0 in EXEC.
  - Captured rsp_result=0, flags={1,0,0,0}.
  - zero flag is forced 0.
REQ-024 RESP: assert rsp_valid only for the granted requester.
  - rsp_result/rsp_flags stable until rsp_ready for that bit is high.
  - On handshake: go to IDLE, ops_done+1, deassert rsp_valid next cycle.
  - rsp_ready on the non-granted bit is ignored.
REQ-025 Latency: accept at cycle N -> EXEC N+1 -> rsp_valid at N+2. Minimum issue interval is 3 cycles (accept -> rsp handshake -> IDLE -> next accept).
REQ-026 A new request is not accepted in the same cycle as a response handshake; it is accepted earliest in the following IDLE cycle.
REQ-027 The err flag SHALL be 0 for every legal op. ALU flag values are passed through unmodified.

Reset
REQ-028 On rst_n=0 at clk rise:
  - state=IDLE, last_grant=1 (requester 0 wins first tie).
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, alu_*=0, ops_done=0.
REQ-029 Reset in EXEC or RESP SHALL abandon the in-flight op: no response is delivered and ops_done is not incremented.
REQ-030 req_ready SHALL be 0 during any cycle with rst_n=0.

Verification
REQ-031 Single op: req0 ADD a=8'h0F b=8'h01, rsp_ready=1, ALU model returns 8'h10 -> rsp_valid=2'b01 at accept+2, rsp_result=8'h10, flags=4'b0000, ops_done=1.
REQ-032 Tie from reset: both valid -> req0 granted first, then req1, then req0. Grant order with both held valid for 3 ops = 0,1,0.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_result held, req_ready=2'b00 throughout; release -> single completion.
REQ-034 Illegal op: req1 op=3'b111 a=8'hFF -> alu_op/a/b stay 0, rsp_valid=2'b10, rsp_result=0, flags=4'b1000.
REQ-035 Reset mid-op: rst_n=0 in EXEC -> next cycle IDLE, rsp_valid=0, ops_done unchanged at 0; subsequent tie grants req0.
REQ-036 Counter wrap: 256 completed ops -> ops_done returns to 8'h00.
